// File: rtl/sample_sequencer.sv
// Sample sequencer: walks BRAM addresses 0..LAST_ADDR on a sample-rate tick
// derived from CLK100MHZ, captures each read word with a one-cycle valid strobe,
// then issues DRAIN_TICKS extra pipe_en pulses to flush the downstream chain.
// BRAM_LAT must be >= 1 and DIV >= BRAM_LAT+2 so a read finishes before the next tick.
module sample_sequencer #(
    parameter int DIV         = 12500,
    parameter int ADDR_W      = 8,
    parameter int LAST_ADDR   = 79,
    parameter int BRAM_LAT    = 1,
    parameter int DRAIN_TICKS = 4
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_mode,
    output logic              ena,
    output logic [ADDR_W-1:0] addra,
    input  logic [7:0]        douta,
    output logic [7:0]        sample_out,
    output logic              sample_valid,
    output logic              pipe_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sample_count
);

    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int LAT_W = (BRAM_LAT > 0) ? $clog2(BRAM_LAT + 1) : 1;
    localparam int DRN_W = $clog2(DRAIN_TICKS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(BRAM_LAT);
    localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(DRAIN_TICKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {IDLE, RUN, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sout_q, sout_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              stop_pend_q, stop_pend_d;
    logic              start_q, stop_q;
    // A level held through reset is not an edge: rises count only once the
    // edge registers have seen one real sample after reset release.
    logic              arm_q;

    logic start_rise, stop_rise, tick;

    assign start_rise   = start & ~start_q & arm_q;
    assign stop_rise    = stop  & ~stop_q  & arm_q;
    assign busy         = (state_q == RUN) || (state_q == READ) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign tick         = busy && (div_q == DIV_LAST);
    assign pipe_en      = tick;
    assign ena          = (state_q == RUN) || (state_q == READ);
    assign sample_valid = (state_q == READ) && (lat_q == '0);
    assign addra        = addr_q;
    assign sample_out   = sout_q;
    assign sample_count = cnt_q;

    // Edge-detect history for start/stop.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            arm_q   <= 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_q       <= '0;
            lat_q       <= '0;
            drain_q     <= '0;
            addr_q      <= '0;
            sout_q      <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            lat_q       <= lat_d;
            drain_q     <= drain_d;
            addr_q      <= addr_d;
            sout_q      <= sout_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Next-state logic: divider, read latency, address walk, drain.
    always_comb begin
        state_d     = state_q;
        div_d       = busy ? (tick ? '0 : div_q + 1'b1) : '0;
        lat_d       = lat_q;
        drain_d     = drain_q;
        addr_d      = addr_q;
        sout_d      = sout_q;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;

        case (state_q)
            IDLE, DONE: begin
                // stop is ignored in DONE; a simultaneous stop vetoes start in IDLE
                if (start_rise && (state_q == DONE || !stop_rise)) begin
                    state_d     = RUN;
                    addr_d      = '0;
                    cnt_d       = '0;
                    lat_d       = '0;
                    drain_d     = '0;
                    stop_pend_d = 1'b0;
                end
            end
            RUN: begin
                if (stop_rise) stop_pend_d = 1'b1;
                if (tick) begin
                    state_d = READ;
                    lat_d   = LAT_INIT;
                end
            end
            READ: begin
                if (stop_rise) stop_pend_d = 1'b1;
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                    // douta is valid by the last latency cycle; capture so the
                    // word and its count appear together with sample_valid
                    if (lat_q == LAT_W'(1)) begin
                        sout_d = douta;
                        cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    end
                end else begin
                    // valid cycle: decide where to go next
                    if (stop_pend_q || stop_rise) begin
                        state_d     = DRAIN;
                        drain_d     = '0;
                        stop_pend_d = 1'b0;
                    end else if (addr_q == ADDR_LAST) begin
                        if (loop_mode) begin
                            addr_d  = '0;
                            state_d = RUN;
                        end else begin
                            state_d = DRAIN;
                            drain_d = '0;
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = RUN;
                    end
                end
            end
            DRAIN: begin
                if (tick) begin
                    if (drain_q == DRN_LAST) begin
                        state_d = DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer with a small registered BRAM model
// (data = addr + 0x10) and a passive monitor logging every emitted sample.
module tb_sample_sequencer;

    logic       CLK100MHZ, reset, start, stop, loop_mode;
    logic       ena, sample_valid, pipe_en, busy, done;
    logic [7:0] addra, douta, sample_out;
    logic [15:0] sample_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_tick = 0;
    int n_ticks = 0;
    logic [7:0] vq[$];
    int vl[$];
    int vc[$];

    sample_sequencer #(
        .DIV(8), .ADDR_W(8), .LAST_ADDR(3), .BRAM_LAT(1), .DRAIN_TICKS(4)
    ) dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .stop(stop),
        .loop_mode(loop_mode), .ena(ena), .addra(addra), .douta(douta),
        .sample_out(sample_out), .sample_valid(sample_valid), .pipe_en(pipe_en),
        .busy(busy), .done(done), .sample_count(sample_count)
    );

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    // one-cycle-latency BRAM
    always @(posedge CLK100MHZ) if (ena) douta <= addra + 8'h10;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    // record each sample with its tick-to-valid distance and cycle stamp
    always @(negedge CLK100MHZ) begin
        if (pipe_en) begin
            last_tick <= cyc;
            n_ticks   <= n_ticks + 1;
        end
        if (sample_valid) begin
            vq.push_back(sample_out);
            vl.push_back(cyc - last_tick);
            vc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 400) begin
            step();
            k++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic wait_samples(input string tag, input int target);
        int k = 0;
        while (vq.size() < target && k < 400) begin
            step();
            k++;
        end
        chk(tag, (vq.size() >= target), 1'b1);
    endtask

    // expected words follow addr+0x10 over a 4-entry table
    task automatic check_samples(input string tag, input int base, input int n);
        chk({tag, "_n"}, vq.size() - base, n);
        for (int i = 0; i < n && base + i < vq.size(); i++) begin
            chk({tag, "_data"}, vq[base+i], 8'h10 + (i % 4));
            chk({tag, "_lat"}, vl[base+i], 2);
            if (i > 0) chk({tag, "_gap"}, vc[base+i] - vc[base+i-1], 8);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {ena, sample_valid, pipe_en, busy, done}, 0);
        chk({tag, "_addr"}, addra, 0);
        chk({tag, "_sout"}, sample_out, 0);
        chk({tag, "_cnt"}, sample_count, 0);
    endtask

    initial begin
        int base, tb0;
        reset = 1'b0; start = 1'b1; stop = 1'b0; loop_mode = 1'b0;

        // reset held with start high
        repeat (3) step();
        check_zero("rst");
        reset = 1'b1;
        repeat (5) step();
        chk("rel_idle_busy", busy, 1'b0);
        chk("rel_idle_nv", vq.size(), 0);
        start = 1'b0;
        step();

        // one-shot, with a start re-pulse mid-run
        base = vq.size(); tb0 = n_ticks;
        pulse_start();
        chk("os_busy", busy, 1'b1);
        wait_samples("os_first", base + 1);
        pulse_start();
        wait_done("os_done");
        repeat (20) step();
        check_samples("os", base, 4);
        chk("os_cnt", sample_count, 4);
        chk("os_ena", ena, 1'b0);
        chk("os_ticks", n_ticks - tb0, 8);

        // restart from DONE repeats the run
        base = vq.size(); tb0 = n_ticks;
        pulse_start();
        chk("rs_addr", addra, 0);
        chk("rs_cnt", sample_count, 0);
        chk("rs_busy", busy, 1'b1);
        wait_done("rs_done");
        check_samples("rs", base, 4);
        chk("rs_cnt_end", sample_count, 4);
        chk("rs_ticks", n_ticks - tb0, 8);

        // loop mode, stop after 10 samples
        loop_mode = 1'b1;
        base = vq.size(); tb0 = n_ticks;
        pulse_start();
        wait_samples("lp_ten", base + 10);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done("lp_done");
        repeat (20) step();
        check_samples("lp", base, 11);
        chk("lp_cnt", sample_count, 11);
        chk("lp_ticks", n_ticks - tb0, 15);
        loop_mode = 1'b0;

        // stop rising the cycle after the 2nd tick
        base = vq.size(); tb0 = n_ticks;
        pulse_start();
        begin
            int k = 0;
            while (n_ticks - tb0 < 2 && k < 100) begin step(); k++; end
        end
        chk("sf_tick2", n_ticks - tb0, 2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done("sf_done");
        repeat (20) step();
        check_samples("sf", base, 2);
        chk("sf_cnt", sample_count, 2);
        chk("sf_ticks", n_ticks - tb0, 6);

        // asynchronous reset in the middle of a read
        base = vq.size(); tb0 = n_ticks;
        pulse_start();
        begin
            int k = 0;
            while (n_ticks - tb0 < 1 && k < 100) begin step(); k++; end
        end
        chk("ar_pre_ena", ena, 1'b1);
        chk("ar_pre_sout", sample_out, 8'h11);
        #2 reset = 1'b0;
        #1 check_zero("ar");
        step();
        reset = 1'b1;
        repeat (30) step();
        chk("ar_nv", vq.size() - base, 0);
        chk("ar_idle", busy, 1'b0);

        // start and stop rise together in IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        repeat (20) step();
        chk("ss_busy", busy, 1'b0);
        chk("ss_done", done, 1'b0);
        chk("ss_nv", vq.size() - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
